// File: rtl/zap_fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : zap_fifo_arb_pkg
// Brief    : Arbiter FSM state encoding and the {tag,data} packing helper
//            shared by the zap_fifo_wr_arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package zap_fifo_arb_pkg;

  // ST_LOCK is only entered when ZAP_FIFO_ARB_LOCK_EN is defined.
  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCK   = 2'd1,
    ST_CLR    = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Widest {tag,data} word the packing helper can build.
  localparam int PACK_MAX = 128;

  // Places the requester tag directly above a data_w-bit data field.
  function automatic logic [PACK_MAX-1:0] pack_tag_data(
    input logic [PACK_MAX-1:0] tag,
    input logic [PACK_MAX-1:0] data,
    input int                  data_w
  );
    return (tag << data_w) | data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zap_fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : zap_fifo_wr_arbiter_if
// Brief     : Requester-side and FIFO-write-side signals of the arbiter.
//             master = requesters/FIFO environment, slave = the arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface zap_fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  localparam int TAGW = $clog2(NREQ);

  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_data;
  logic [NREQ-1:0]       i_last;
  logic [NREQ-1:0]       o_gnt;
  logic                  i_fifo_full;
  logic                  o_fifo_wr_en;
  logic [WIDTH+TAGW-1:0] o_fifo_data;
  logic                  i_flush;
  logic                  o_fifo_clear;
  logic                  o_busy;

  modport master (
    output i_req, i_data, i_last, i_fifo_full, i_flush,
    input  o_gnt, o_fifo_wr_en, o_fifo_data, o_fifo_clear, o_busy
  );

  modport slave (
    input  i_req, i_data, i_last, i_fifo_full, i_flush,
    output o_gnt, o_fifo_wr_en, o_fifo_data, o_fifo_clear, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/zap_fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : zap_rr_pick
// Brief    : Combinational rotating priority encoder. Scans ptr, ptr+1, ...
//            modulo NREQ and returns the first requester found.
// Revision : 1.0 - initial release
// ============================================================================
module zap_rr_pick #(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [TAGW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [TAGW-1:0] idx_o,
  output logic            valid_o
);

  logic [TAGW-1:0] cand_w;

  // Walk offsets from farthest to nearest so the nearest requester wins;
  // wrap is an explicit subtraction so non-power-of-2 NREQ works.
  always_comb begin
    int cand;
    cand    = 0;
    cand_w  = '0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = int'(ptr_i) + off;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_w = TAGW'(cand);
      if (req_i[cand_w]) begin
        gnt_o         = '0;
        gnt_o[cand_w] = 1'b1;
        idx_o         = cand_w;
        valid_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/zap_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zap_fifo_wr_arbiter
// Brief    : Round-robin arbiter sharing one zap_sync_fifo write port among
//            NREQ requesters; tags words with the requester index and
//            sequences FIFO clear so no write races it.
// Options  : ZAP_FIFO_ARB_LOCK_EN - burst lock until i_last.
// Revision : 1.0 - initial release
// ============================================================================
module zap_fifo_wr_arbiter
  import zap_fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input logic                  i_clk,
  input logic                  i_reset,
  zap_fifo_wr_arbiter_if.slave bus
);

  localparam int              TAGW     = $clog2(NREQ);
  localparam logic [TAGW-1:0] LAST_IDX = TAGW'(NREQ - 1);

  state_t              state_q, state_d;
  logic [TAGW-1:0]     rr_q, rr_d;
  logic [NREQ-1:0]     req_eff_w;
  logic [NREQ-1:0]     pick_gnt_w;
  logic [TAGW-1:0]     pick_idx_w;
  logic                pick_valid_w;
  logic                grant_ok_w;
  logic                wr_en_w;
  logic [WIDTH-1:0]    win_data_w;
  logic [PACK_MAX-1:0] pack_w;
  logic                pack_unused_w;

`ifdef ZAP_FIFO_ARB_LOCK_EN
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  logic [TAGW-1:0] owner_q, owner_d;

  // While locked, only the burst owner is visible to the picker.
  always_comb begin
    req_eff_w = bus.i_req;
    if (state_q == ST_LOCK) begin
      req_eff_w = bus.i_req & (ONE << owner_q);
    end
  end
`else
  logic last_unused_w;
  assign req_eff_w     = bus.i_req;
  assign last_unused_w = |bus.i_last;
`endif

  zap_rr_pick #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_pick (
    .req_i   (req_eff_w),
    .ptr_i   (rr_q),
    .gnt_o   (pick_gnt_w),
    .idx_o   (pick_idx_w),
    .valid_o (pick_valid_w)
  );

  // Flush and full both block the write in the same cycle they are seen.
  assign grant_ok_w = ~i_reset & ((state_q == ST_ARB) | (state_q == ST_LOCK))
                    & ~bus.i_fifo_full & ~bus.i_flush;
  assign wr_en_w    = grant_ok_w & pick_valid_w;
  assign win_data_w = bus.i_data[pick_idx_w*WIDTH +: WIDTH];

  assign pack_w        = pack_tag_data(PACK_MAX'(pick_idx_w), PACK_MAX'(win_data_w), WIDTH);
  assign pack_unused_w = ^pack_w[PACK_MAX-1:WIDTH+TAGW];

  assign bus.o_fifo_wr_en = wr_en_w;
  assign bus.o_gnt        = wr_en_w ? pick_gnt_w : '0;
  assign bus.o_fifo_data  = pack_w[WIDTH+TAGW-1:0];
  assign bus.o_fifo_clear = (state_q == ST_CLR);
  assign bus.o_busy       = (state_q == ST_CLR) | (state_q == ST_SETTLE);

  // Next-state, round-robin pointer and burst owner.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
`ifdef ZAP_FIFO_ARB_LOCK_EN
    owner_d = owner_q;
`endif
    if (wr_en_w) begin
      rr_d = (pick_idx_w == LAST_IDX) ? '0 : pick_idx_w + 1'b1;
    end
    case (state_q)
      ST_ARB: begin
        if (bus.i_flush) begin
          state_d = ST_CLR;
        end
`ifdef ZAP_FIFO_ARB_LOCK_EN
        else if (wr_en_w && !bus.i_last[pick_idx_w]) begin
          state_d = ST_LOCK;
          owner_d = pick_idx_w;
        end
`endif
      end
      ST_LOCK: begin
`ifdef ZAP_FIFO_ARB_LOCK_EN
        if (bus.i_flush) begin
          state_d = ST_CLR;
        end else if (wr_en_w && bus.i_last[pick_idx_w]) begin
          state_d = ST_ARB;
        end
`else
        state_d = ST_ARB;
`endif
      end
      ST_CLR:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = bus.i_flush ? ST_CLR : ST_ARB;
      default:   state_d = ST_ARB;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_ARB;
      rr_q    <= '0;
`ifdef ZAP_FIFO_ARB_LOCK_EN
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
`ifdef ZAP_FIFO_ARB_LOCK_EN
      owner_q <= owner_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zap_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_zap_fifo_wr_arbiter
// Brief    : Directed self-checking bench for zap_fifo_wr_arbiter with a
//            4-requester and a 3-requester instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zap_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  zap_fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(32)) bus4 ();
  zap_fifo_wr_arbiter_if #(.NREQ(3), .WIDTH(8))  bus3 ();

  zap_fifo_wr_arbiter #(.NREQ(4), .WIDTH(32)) dut4 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus4)
  );

  zap_fifo_wr_arbiter #(.NREQ(3), .WIDTH(8)) dut3 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus3)
  );

`ifdef ZAP_FIFO_ARB_LOCK_EN
  localparam int LK_N = 4;
  logic [3:0] lk_exp [LK_N] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
  localparam int LK_N = 5;
  logic [3:0] lk_exp [LK_N] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int          w0;
    int          sent [3];
    int          pushes;
    logic [1:0]  tag;
    logic [9:0]  q [$];
    logic        full3;

    bus4.i_req = '0; bus4.i_last = '0; bus4.i_fifo_full = 1'b0; bus4.i_flush = 1'b0;
    bus4.i_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    bus3.i_req = '0; bus3.i_last = '1; bus3.i_fifo_full = 1'b0; bus3.i_flush = 1'b0;
    bus3.i_data = {8'h32, 8'h31, 8'h30};

    // Reset: grants suppressed while reset is high.
    cyc();
    bus4.i_req = 4'hF;
    #1;
    chk("rst_gnt", bus4.o_gnt, 0);
    chk("rst_wr_en", bus4.o_fifo_wr_en, 0);
    cyc();
    rst = 1'b0;
    bus4.i_req = '0;
    #1;
    chk("rst_busy", bus4.o_busy, 0);
    chk("rst_clear", bus4.o_fifo_clear, 0);
    chk("rst_rr", dut4.rr_q, 0);
    cyc();

    // Fairness: everyone requesting gives 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      bus4.i_req = 4'hF;
      #1;
      chk("fair_gnt", bus4.o_gnt, 64'(1) << (i % 4));
      chk("fair_data", bus4.o_fifo_data, {2'(i % 4), 32'hA0 + 32'(i % 4)});
      cyc();
    end

    // Full stall: no write, pointer frozen; grant the cycle full drops.
    for (int i = 0; i < 3; i++) begin
      bus4.i_req = 4'b0100;
      bus4.i_fifo_full = 1'b1;
      #1;
      chk("full_wr_en", bus4.o_fifo_wr_en, 0);
      chk("full_gnt", bus4.o_gnt, 0);
      cyc();
    end
    chk("full_rr", dut4.rr_q, 0);
    bus4.i_fifo_full = 1'b0;
    #1;
    chk("full_release_gnt", bus4.o_gnt, 4'b0100);
    chk("full_release_data", bus4.o_fifo_data, {2'd2, 32'hA2});
    cyc();

    // Flush collision: flush beats requests, then CLR, SETTLE, resume at rr=3.
    bus4.i_req = 4'hF;
    bus4.i_flush = 1'b1;
    #1;
    chk("flush_col_gnt", bus4.o_gnt, 0);
    chk("flush_col_clear", bus4.o_fifo_clear, 0);
    cyc();
    bus4.i_flush = 1'b0;
    #1;
    chk("clr_clear", bus4.o_fifo_clear, 1);
    chk("clr_busy", bus4.o_busy, 1);
    chk("clr_gnt", bus4.o_gnt, 0);
    cyc();
    chk("settle_clear", bus4.o_fifo_clear, 0);
    chk("settle_busy", bus4.o_busy, 1);
    chk("settle_gnt", bus4.o_gnt, 0);
    cyc();
    chk("resume_gnt", bus4.o_gnt, 4'b1000);
    cyc();
    bus4.i_req = '0;

    // Flush held across SETTLE restarts the clear.
    bus4.i_flush = 1'b1;
    cyc();
    chk("hold_clr1", bus4.o_fifo_clear, 1);
    cyc();
    chk("hold_settle", bus4.o_fifo_clear, 0);
    cyc();
    bus4.i_flush = 1'b0;
    #1;
    chk("hold_clr2", bus4.o_fifo_clear, 1);
    cyc();
    cyc();
    chk("hold_done_busy", bus4.o_busy, 0);

    // Reset mid-flush after moving the pointer off 0.
    bus4.i_req = 4'b0001;
    #1;
    chk("pre_rst_gnt", bus4.o_gnt, 4'b0001);
    cyc();
    bus4.i_req = '0;
    bus4.i_flush = 1'b1;
    cyc();
    bus4.i_flush = 1'b0;
    #1;
    chk("mid_clr", bus4.o_fifo_clear, 1);
    rst = 1'b1;
    bus4.i_req = 4'hF;
    #1;
    chk("mid_rst_gnt", bus4.o_gnt, 0);
    cyc();
    rst = 1'b0;
    bus4.i_req = '0;
    #1;
    chk("post_rst_clear", bus4.o_fifo_clear, 0);
    chk("post_rst_busy", bus4.o_busy, 0);
    chk("post_rst_gnt", bus4.o_gnt, 0);
    cyc();
    bus4.i_req = 4'hF;
    #1;
    chk("post_rst_first", bus4.o_gnt, 4'b0001);
    cyc();

    // Move pointer to 0 before the burst test.
    bus4.i_req = 4'b1000;
    bus4.i_last = 4'b1111;
    #1;
    chk("lk_setup", bus4.o_gnt, 4'b1000);
    cyc();

    // Burst of 3 on requester 0 (last on the 3rd), requester 1 steady.
    w0 = 0;
    for (int i = 0; i < LK_N; i++) begin
      bus4.i_req  = {2'b00, 1'b1, (w0 < 3)};
      bus4.i_last = {2'b00, 1'b1, (w0 == 2)};
      bus4.i_data = {32'hA3, 32'hA2, 32'hA1, 32'hB0 + 32'(w0)};
      #1;
      chk("lock_gnt", bus4.o_gnt, lk_exp[i]);
      if (bus4.o_gnt[0]) w0++;
      cyc();
    end
    chk("lock_words", w0, 3);
    bus4.i_req = '0;
    bus4.i_last = '0;

    // NREQ=3 wrap: 0,1,2,0.
    for (int i = 0; i < 4; i++) begin
      bus3.i_req = 3'b111;
      #1;
      chk("wrap_gnt", bus3.o_gnt, 64'(1) << (i % 3));
      chk("wrap_data", bus3.o_fifo_data, {2'(i % 3), 8'h30 + 8'(i % 3)});
      cyc();
    end

    // Scoreboard against a depth-2 FIFO model drained every other cycle.
    sent = '{0, 0, 0};
    pushes = 0;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < 3; k++) begin
        bus3.i_req[k] = (sent[k] < 4);
        bus3.i_data[k*8 +: 8] = {4'(k), 4'(sent[k])};
      end
      full3 = (q.size() >= 2);
      bus3.i_fifo_full = full3;
      #1;
      chk("sb_wr_while_full", bus3.o_fifo_wr_en & full3, 0);
      if (bus3.o_fifo_wr_en) begin
        tag = bus3.o_fifo_data[9:8];
        chk("sb_tag_range", (tag < 2'd3), 1);
        if (tag < 2'd3) begin
          chk("sb_word", bus3.o_fifo_data[7:0], {4'(tag), 4'(sent[tag])});
          chk("sb_gnt_tag", bus3.o_gnt, 64'(1) << tag);
          sent[tag]++;
        end
        q.push_back(bus3.o_fifo_data);
        pushes++;
      end
      if ((c % 2 == 1) && (q.size() > 0)) void'(q.pop_front());
      cyc();
    end
    chk("sb_pushes", pushes, 12);
    for (int k = 0; k < 3; k++) chk("sb_sent", sent[k], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
